// File: rtl/command_loader.sv
// Byte-stream command loader: parses PING / IMEM / BMEM / UPDATE commands from a UART
// byte stream, issues memory write and thread-control strobes, and returns one response byte.
module command_loader #(
    parameter int BITWIDTH       = 32,
    parameter int NUM_THREADS    = 2,
    parameter int BMEM_WORDS     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [7:0]                     rsp_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [NUM_THREADS-1:0]         imem_write_valid,
    output logic [BITWIDTH-1:0]            imem_write_addr,
    output logic [BITWIDTH-1:0]            imem_write_data,
    output logic                           bmem_write_valid,
    output logic [BITWIDTH-1:0]            bmem_write_addr,
    output logic [BITWIDTH*BMEM_WORDS-1:0] bmem_write_data,
    output logic [NUM_THREADS-1:0]         thread_start,
    output logic [NUM_THREADS-1:0]         thread_enabled,
    output logic                           error
);

    localparam int BYTES       = BITWIDTH / 8;
    localparam int BURST_BYTES = BMEM_WORDS * BYTES;
    localparam int BURST_BITS  = BITWIDTH * BMEM_WORDS;
    localparam int CNT_W       = $clog2(BURST_BYTES + 1);
    localparam int IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_PING   = 2'b00;
    localparam logic [1:0] OP_IMEM   = 2'b01;
    localparam logic [1:0] OP_UPDATE = 2'b11;

    localparam logic [7:0] RSP_PING    = 8'h55;
    localparam logic [7:0] RSP_OK      = 8'hA5;
    localparam logic [7:0] RSP_BAD_CH  = 8'hE1;
    localparam logic [7:0] RSP_BUSY_CH = 8'hE2;
    localparam logic [7:0] RSP_TIMEOUT = 8'hE3;

    typedef enum logic [2:0] {
        START, ADDR, IMEM_DATA, BMEM_DATA, UPD_START, UPD_EN, RESP
    } state_t;

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [2:0]              chan_q;
    logic [CNT_W-1:0]        byte_cnt_q;
    logic [IDLE_W-1:0]       idle_cnt_q;
    logic [BITWIDTH-1:0]     addr_q;
    logic [BURST_BITS-1:0]   buf_q;
    logic [NUM_THREADS-1:0]  start_mask_q;

    logic [7:0]              rsp_data_q;
    logic                    rsp_valid_q;
    logic                    error_q;
    logic [NUM_THREADS-1:0]  imem_valid_q;
    logic [BITWIDTH-1:0]     imem_addr_q;
    logic [BITWIDTH-1:0]     imem_data_q;
    logic                    bmem_valid_q;
    logic [BITWIDTH-1:0]     bmem_addr_q;
    logic [BURST_BITS-1:0]   bmem_data_q;
    logic [NUM_THREADS-1:0]  thread_start_q;
    logic [NUM_THREADS-1:0]  thread_enabled_q;

    logic                    accept;
    logic                    collecting;
    logic                    timeout;
    logic                    chan_ok;
    logic                    chan_busy;
    logic [7:0]              en_pad;
    logic [NUM_THREADS-1:0]  chan_onehot;
    logic [BITWIDTH-1:0]     imem_word;
    logic [BURST_BITS-1:0]   burst_word;

    // Valid/ready: a byte moves on in_valid && in_ready, a response on rsp_valid && rsp_ready;
    // the loader stalls input only while a response is pending.
    assign in_ready = (state_q != RESP);
    assign accept   = in_valid && in_ready;

    always_comb begin
        collecting = (state_q == ADDR) || (state_q == IMEM_DATA) || (state_q == BMEM_DATA) ||
                     (state_q == UPD_START) || (state_q == UPD_EN);
        timeout    = collecting && !accept && (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));
        chan_ok    = ({1'b0, chan_q} < 4'(NUM_THREADS));
        en_pad     = '0;
        en_pad[NUM_THREADS-1:0] = thread_enabled_q;
        chan_busy  = en_pad[chan_q];
        for (int i = 0; i < NUM_THREADS; i++) begin
            chan_onehot[i] = (chan_q == 3'(i));
        end
        // The final byte is still on in_data when the write is committed.
        imem_word  = buf_q[BITWIDTH-1:0];
        imem_word[BITWIDTH-8 +: 8] = in_data;
        burst_word = buf_q;
        burst_word[BURST_BITS-8 +: 8] = in_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= START;
            op_q             <= '0;
            chan_q           <= '0;
            byte_cnt_q       <= '0;
            idle_cnt_q       <= '0;
            addr_q           <= '0;
            buf_q            <= '0;
            start_mask_q     <= '0;
            rsp_data_q       <= '0;
            rsp_valid_q      <= 1'b0;
            error_q          <= 1'b0;
            imem_valid_q     <= '0;
            imem_addr_q      <= '0;
            imem_data_q      <= '0;
            bmem_valid_q     <= 1'b0;
            bmem_addr_q      <= '0;
            bmem_data_q      <= '0;
            thread_start_q   <= '0;
            thread_enabled_q <= '0;
        end else begin
            imem_valid_q   <= '0;
            bmem_valid_q   <= 1'b0;
            thread_start_q <= '0;
            error_q        <= 1'b0;
            idle_cnt_q     <= (collecting && !accept && !timeout) ? idle_cnt_q + IDLE_W'(1) : '0;

            if (timeout) begin
                rsp_data_q  <= RSP_TIMEOUT;
                rsp_valid_q <= 1'b1;
                error_q     <= 1'b1;
                state_q     <= RESP;
            end else begin
                case (state_q)
                    START: if (accept) begin
                        byte_cnt_q <= '0;
                        op_q       <= in_data[7:6];
                        chan_q     <= in_data[2:0];
                        case (in_data[7:6])
                            OP_PING: begin
                                rsp_data_q  <= RSP_PING;
                                rsp_valid_q <= 1'b1;
                                state_q     <= RESP;
                            end
                            OP_UPDATE: state_q <= UPD_START;
                            default:   state_q <= ADDR;
                        endcase
                    end
                    ADDR: if (accept) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (byte_cnt_q == CNT_W'(b)) addr_q[b*8 +: 8] <= in_data;
                        end
                        if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                            byte_cnt_q <= '0;
                            state_q    <= (op_q == OP_IMEM) ? IMEM_DATA : BMEM_DATA;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end
                    end
                    IMEM_DATA: if (accept) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (byte_cnt_q == CNT_W'(b)) buf_q[b*8 +: 8] <= in_data;
                        end
                        if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                            byte_cnt_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                            if (!chan_ok) begin
                                rsp_data_q <= RSP_BAD_CH;
                                error_q    <= 1'b1;
                            end else if (chan_busy) begin
                                rsp_data_q <= RSP_BUSY_CH;
                                error_q    <= 1'b1;
                            end else begin
                                rsp_data_q   <= RSP_OK;
                                imem_valid_q <= chan_onehot;
                                imem_addr_q  <= addr_q;
                                imem_data_q  <= imem_word;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end
                    end
                    BMEM_DATA: if (accept) begin
                        for (int b = 0; b < BURST_BYTES; b++) begin
                            if (byte_cnt_q == CNT_W'(b)) buf_q[b*8 +: 8] <= in_data;
                        end
                        if (byte_cnt_q == CNT_W'(BURST_BYTES - 1)) begin
                            byte_cnt_q   <= '0;
                            bmem_valid_q <= 1'b1;
                            bmem_addr_q  <= addr_q;
                            bmem_data_q  <= burst_word;
                            rsp_data_q   <= RSP_OK;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end
                    end
                    UPD_START: if (accept) begin
                        start_mask_q <= in_data[NUM_THREADS-1:0];
                        state_q      <= UPD_EN;
                    end
                    UPD_EN: if (accept) begin
                        thread_start_q   <= start_mask_q;
                        thread_enabled_q <= in_data[NUM_THREADS-1:0];
                        rsp_data_q       <= RSP_OK;
                        rsp_valid_q      <= 1'b1;
                        state_q          <= RESP;
                    end
                    RESP: if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= START;
                    end
                    default: state_q <= START;
                endcase
            end
        end
    end

    assign rsp_data         = rsp_data_q;
    assign rsp_valid        = rsp_valid_q;
    assign error            = error_q;
    assign imem_write_valid = imem_valid_q;
    assign imem_write_addr  = imem_addr_q;
    assign imem_write_data  = imem_data_q;
    assign bmem_write_valid = bmem_valid_q;
    assign bmem_write_addr  = bmem_addr_q;
    assign bmem_write_data  = bmem_data_q;
    assign thread_start     = thread_start_q;
    assign thread_enabled   = thread_enabled_q;

endmodule

// File: tb/tb_command_loader.sv
// Bench for command_loader: directed scenarios plus randomized commands checked against a
// byte-level command model and a response queue.
module tb_command_loader;

    localparam int BW     = 32;
    localparam int NT     = 2;
    localparam int BWORDS = 4;
    localparam int TO     = 100;
    localparam int BURST  = BW * BWORDS;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [NT-1:0]     imem_write_valid;
    logic [BW-1:0]     imem_write_addr;
    logic [BW-1:0]     imem_write_data;
    logic              bmem_write_valid;
    logic [BW-1:0]     bmem_write_addr;
    logic [BURST-1:0]  bmem_write_data;
    logic [NT-1:0]     thread_start;
    logic [NT-1:0]     thread_enabled;
    logic              error;

    command_loader #(
        .BITWIDTH(BW), .NUM_THREADS(NT), .BMEM_WORDS(BWORDS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .imem_write_valid(imem_write_valid), .imem_write_addr(imem_write_addr),
        .imem_write_data(imem_write_data),
        .bmem_write_valid(bmem_write_valid), .bmem_write_addr(bmem_write_addr),
        .bmem_write_data(bmem_write_data),
        .thread_start(thread_start), .thread_enabled(thread_enabled), .error(error)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  cmd_q[$];

    logic [NT-1:0]    m_en;
    logic [BW-1:0]    m_imem_addr, m_imem_data, m_bmem_addr;
    logic [BURST-1:0] m_bmem_data;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en        = '0;
        m_imem_addr = '0;
        m_imem_data = '0;
        m_bmem_addr = '0;
        m_bmem_data = '0;
        exp_q.delete();
    endtask

    // ---------------- drivers (enter and leave just after a falling edge) ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) check_eq("in_ready_wait", 128'(in_ready), 128'(1'b1));
        else @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [BW-1:0] w);
        for (int i = 0; i < BW / 8; i++) cmd_q.push_back(8'((w >> (8 * i)) & 8'hFF));
    endtask

    task automatic build_imem(input int ch, input logic [BW-1:0] a, input logic [BW-1:0] d);
        cmd_q.delete();
        cmd_q.push_back({2'b01, 3'($urandom), 3'(ch)});
        push_word(a);
        push_word(d);
    endtask

    task automatic build_bmem(input logic [BW-1:0] a, input logic [BURST-1:0] d);
        cmd_q.delete();
        cmd_q.push_back({2'b10, 6'($urandom)});
        push_word(a);
        for (int w = 0; w < BWORDS; w++) push_word(d[w*BW +: BW]);
    endtask

    task automatic build_update(input logic [7:0] s, input logic [7:0] e);
        cmd_q.delete();
        cmd_q.push_back({2'b11, 6'($urandom)});
        cmd_q.push_back(s);
        cmd_q.push_back(e);
    endtask

    task automatic build_ping();
        cmd_q.delete();
        cmd_q.push_back({2'b00, 6'($urandom)});
    endtask

    // Sends cmd_q, predicts the outcome from the command bytes, and checks the cycle
    // where the response appears plus the following cycle (strobes must be single pulses).
    task automatic run_cmd(input int max_gap);
        logic [1:0]       op;
        int               ch;
        logic [BW-1:0]    a, d;
        logic [BURST-1:0] bd;
        logic [NT-1:0]    exp_imem, exp_start;
        logic             exp_bmem, exp_err;
        logic [7:0]       rsp;
        for (int i = 0; i < cmd_q.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clock);
            send_byte(cmd_q[i]);
        end
        op = cmd_q[0][7:6];
        ch = int'(cmd_q[0][2:0]);
        a = '0; d = '0; bd = '0;
        exp_imem = '0; exp_start = '0; exp_bmem = 1'b0; exp_err = 1'b0;
        rsp = 8'h55;
        if (op == 2'b01 || op == 2'b10) begin
            for (int i = 0; i < BW / 8; i++) a = a + (BW'(cmd_q[1 + i]) << (8 * i));
        end
        case (op)
            2'b01: begin
                for (int i = 0; i < BW / 8; i++) d = d + (BW'(cmd_q[5 + i]) << (8 * i));
                if (ch >= NT) begin
                    rsp = 8'hE1; exp_err = 1'b1;
                end else if (m_en[ch]) begin
                    rsp = 8'hE2; exp_err = 1'b1;
                end else begin
                    rsp = 8'hA5;
                    exp_imem = NT'(1) << ch;
                    m_imem_addr = a;
                    m_imem_data = d;
                end
            end
            2'b10: begin
                for (int i = 0; i < BURST / 8; i++) bd[i*8 +: 8] = cmd_q[5 + i];
                rsp = 8'hA5;
                exp_bmem = 1'b1;
                m_bmem_addr = a;
                m_bmem_data = bd;
            end
            2'b11: begin
                rsp = 8'hA5;
                exp_start = cmd_q[1][NT-1:0];
                m_en = cmd_q[2][NT-1:0];
            end
            default: rsp = 8'h55;
        endcase
        exp_q.push_back(rsp);

        check_eq("rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check_eq("rsp_data", 128'(rsp_data), 128'(exp_q.pop_front()));
        check_eq("error", 128'(error), 128'(exp_err));
        check_eq("imem_valid", 128'(imem_write_valid), 128'(exp_imem));
        check_eq("bmem_valid", 128'(bmem_write_valid), 128'(exp_bmem));
        check_eq("thread_start", 128'(thread_start), 128'(exp_start));
        check_eq("thread_enabled", 128'(thread_enabled), 128'(m_en));
        check_eq("imem_addr", 128'(imem_write_addr), 128'(m_imem_addr));
        check_eq("imem_data", 128'(imem_write_data), 128'(m_imem_data));
        check_eq("bmem_addr", 128'(bmem_write_addr), 128'(m_bmem_addr));
        check_eq("bmem_data", 128'(bmem_write_data), 128'(m_bmem_data));
        @(negedge clock);
        check_eq("imem_valid_end", 128'(imem_write_valid), 128'(0));
        check_eq("bmem_valid_end", 128'(bmem_write_valid), 128'(1'b0));
        check_eq("thread_start_end", 128'(thread_start), 128'(0));
        check_eq("error_end", 128'(error), 128'(1'b0));
        check_eq("rsp_valid_end", 128'(rsp_valid), 128'(1'b0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [BURST-1:0] burst;
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check_eq("rst_error", 128'(error), 128'(1'b0));
        check_eq("rst_thread_enabled", 128'(thread_enabled), 128'(0));
        check_eq("rst_imem_valid", 128'(imem_write_valid), 128'(0));
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_in_ready", 128'(in_ready), 128'(1'b1));

        // IMEM write to channel 0
        cmd_q = '{8'h40, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_cmd(0);

        // UPDATE enabling both threads, then IMEM to enabled channel 1
        cmd_q = '{8'hC0, 8'h03, 8'h03};
        run_cmd(0);
        build_imem(1, 32'h0000_0020, 32'h1234_5678);
        run_cmd(1);
        build_imem(5, 32'h0000_0030, 32'h0BAD_F00D);
        run_cmd(1);

        // BMEM burst with bytes 00..0F
        for (int i = 0; i < BURST / 8; i++) burst[i*8 +: 8] = 8'(i);
        build_bmem(32'h0000_0100, burst);
        run_cmd(0);
        check_eq("bmem_word0", 128'(bmem_write_data[31:0]), 128'(32'h0302_0100));
        check_eq("bmem_word3", 128'(bmem_write_data[127:96]), 128'(32'h0F0E_0D0C));

        // Timeout after a partial IMEM command
        send_byte(8'h40);
        send_byte(8'h10);
        repeat (TO - 1) @(negedge clock);
        check_eq("timeout_early", 128'(rsp_valid), 128'(1'b0));
        @(negedge clock);
        check_eq("timeout_rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check_eq("timeout_rsp", 128'(rsp_data), 128'(8'hE3));
        check_eq("timeout_error", 128'(error), 128'(1'b1));
        check_eq("timeout_no_strobe", 128'(imem_write_valid), 128'(0));
        @(negedge clock);
        build_ping();
        run_cmd(0);

        // Response back-pressure: input must stall while the response is held
        rsp_ready = 1'b0;
        send_byte(8'h00);
        in_data  = 8'hC0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check_eq("bp_rsp_valid", 128'(rsp_valid), 128'(1'b1));
            check_eq("bp_rsp_data", 128'(rsp_data), 128'(8'h55));
            check_eq("bp_in_ready", 128'(in_ready), 128'(1'b0));
            @(negedge clock);
        end
        in_valid  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("bp_released", 128'(rsp_valid), 128'(1'b0));
        build_ping();
        run_cmd(0);

        // Reset in the middle of a BMEM burst
        build_update(8'h00, 8'h01);
        run_cmd(0);
        build_bmem(32'hCAFE_0000, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 9; i++) send_byte(cmd_q[i]);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_bmem_valid", 128'(bmem_write_valid), 128'(1'b0));
        check_eq("mid_rst_bmem_data", 128'(bmem_write_data), 128'(0));
        check_eq("mid_rst_imem_addr", 128'(imem_write_addr), 128'(0));
        check_eq("mid_rst_thread_enabled", 128'(thread_enabled), 128'(0));
        check_eq("mid_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq("post_rst_quiet", 128'({bmem_write_valid, rsp_valid}), 128'(0));
        end
        build_ping();
        run_cmd(0);

        // Randomized command mix
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3, 0))
                0: build_ping();
                1: build_imem($urandom_range(3, 0), $urandom, $urandom);
                2: build_bmem($urandom, {$urandom, $urandom, $urandom, $urandom});
                default: build_update(8'($urandom), 8'($urandom));
            endcase
            run_cmd(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/command_loader.md
COMMAND_LOADER -- requirements
Module: command_loader

Interface
REQ-001 Parameter BITWIDTH, 32, word width in bits; SHALL be a multiple of 8, 8..64.
REQ-002 Parameter NUM_THREADS, 2, thread/IMEM channel count; SHALL be 1..8.
REQ-003 Parameter BMEM_WORDS, 16, words per BMEM burst (MESHUNITS^2*TILEUNITS^2 at integration).
REQ-004 Parameter TIMEOUT_CYCLES, 1_000_000, max idle cycles between bytes of one command.
REQ-005 Ports SHALL be:
  clock  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  in_data  in  8  command byte stream from UART
  in_valid  in  1  in_data valid
  in_ready  out  1  loader accepts byte this cycle
  rsp_data  out  8  response byte to UART
  rsp_valid  out  1  rsp_data valid
  rsp_ready  in  1  UART accepts response
  imem_write_valid  out  NUM_THREADS  one-hot IMEM write strobe
  imem_write_addr  out  BITWIDTH  IMEM address
  imem_write_data  out  BITWIDTH  IMEM word
  bmem_write_valid  out  1  BMEM burst write strobe
  bmem_write_addr  out  BITWIDTH  BMEM base address
  bmem_write_data  out  BITWIDTH*BMEM_WORDS  burst, word i at bits [i*BITWIDTH +: BITWIDTH]
  thread_start  out  NUM_THREADS  one-cycle start pulses
  thread_enabled  out  NUM_THREADS  level enables
  error  out  1  one-cycle pulse on any NACK

Function
REQ-006 Byte transfer SHALL occur when in_valid && in_ready; response transfer when rsp_valid && rsp_ready.
REQ-007 States SHALL be START, ADDR, IMEM_DATA, BMEM_DATA, UPD_START, UPD_EN, RESP.
REQ-008 Header byte in START: bits[7:6] opcode (00 PING, 01 IMEM, 10 BMEM, 11 UPDATE), bits[2:0] channel (IMEM only).
REQ-009 PING -> RESP with rsp_data 8'h55.
REQ-010 IMEM/BMEM -> ADDR; BITWIDTH/8 address bytes, little-endian, then IMEM_DATA (BITWIDTH/8 bytes) or BMEM_DATA (BMEM_WORDS*BITWIDTH/8 bytes, word 0 first, each word little-endian).
REQ-011 IMEM completion: if channel < NUM_THREADS and thread_enabled[channel]==0, imem_write_valid[channel] SHALL pulse for exactly one cycle, the cycle after the last data byte, with addr/data stable; response 8'hA5.
REQ-012 IMEM to channel >= NUM_THREADS -> NACK 8'hE1; to an enabled channel -> NACK 8'hE2; no write strobe in either case; data bytes still consumed.
REQ-013 BMEM completion: bmem_write_valid SHALL pulse one cycle after last byte; response 8'hA5.
REQ-014 UPDATE -> UPD_START (one mask byte) -> UPD_EN (one mask byte); after the second byte, thread_start pulses one cycle with mask[NUM_THREADS-1:0] and thread_enabled loads mask[NUM_THREADS-1:0] on the same edge; mask bits above NUM_THREADS ignored; response 8'hA5.
REQ-015 Write/update strobes SHALL coincide with entry to RESP; rsp_valid asserts that same cycle.
REQ-016 in_ready SHALL be 0 in RESP and 1 in all other states; RESP holds rsp_data until accepted, then -> START.
REQ-017 Idle counter SHALL clear on every accepted byte and count while in ADDR/IMEM_DATA/BMEM_DATA/UPD_*; reaching TIMEOUT_CYCLES -> discard partial command, NACK 8'hE3, no strobes.
REQ-018 error SHALL pulse one cycle with every NACK entry into RESP.
REQ-019 Output address/data registers SHALL hold last value until overwritten; thread_enabled holds until next UPDATE.
REQ-020 Byte counter SHALL be wide enough for BMEM_WORDS*BITWIDTH/8 without wrap.

Reset
REQ-021 reset low SHALL asynchronously force START, counters 0, all strobes, rsp_valid, error, thread_start, thread_enabled to 0; in_ready 1 after release.
REQ-022 reset mid-command SHALL discard the partial command with no write strobe and no response.

Verification (BITWIDTH=32, NUM_THREADS=2, BMEM_WORDS=4, TIMEOUT_CYCLES=100)
REQ-023 Bytes 40,10,00,00,00,EF,BE,AD,DE -> imem_write_valid=01 one cycle, addr 0x10, data 0xDEADBEEF, rsp A5.
REQ-024 Bytes C0,03,03 then 41,... -> thread_start 11 pulse, thread_enabled 11, rsp A5; IMEM to ch1 -> rsp E2, no strobe, error pulse.
REQ-025 Bytes 80, addr 0x100, 16 data bytes 00..0F -> bmem_write_valid one cycle, word0 0x03020100, word3 0x0F0E0D0C, rsp A5.
REQ-026 Send 40,10 then idle 100 cycles -> rsp E3, error pulse; next 00 -> rsp 55.
REQ-027 Hold rsp_ready=0 for 20 cycles after PING -> rsp_valid and 8'h55 stable, in_ready 0, in bytes not consumed.
REQ-028 Assert reset low mid-BMEM burst -> all outputs 0 immediately, no bmem_write_valid; subsequent PING -> 55.
